// File: rtl/pcpi_lockstep_cmp.sv
// Lockstep checker: a golden PCPI co-processor drives the core while its results are
// matched against a DUT co-processor via a skew FIFO. Macro PCPI_LOCKSTEP_CAPTURE_EN adds first-error capture.
module pcpi_lockstep_cmp #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAX_LAT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             a_ready,
   input  logic             a_wait,
   input  logic             a_wr,
   input  logic [XLEN-1:0]  a_rd,
   input  logic             b_ready,
   input  logic             b_wait,
   input  logic             b_wr,
   input  logic [XLEN-1:0]  b_rd,
   input  logic             clr,
   output logic             pcpi_ready,
   output logic             pcpi_wait,
   output logic             pcpi_wr,
   output logic [XLEN-1:0]  pcpi_rd,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       err_code,
   output logic [XLEN-1:0]  err_rd_a,
   output logic [XLEN-1:0]  err_rd_b
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AW = $clog2(MAX_LAT + 1);
   localparam int unsigned EW = XLEN + 1;
   localparam logic [PW:0]   FULL_OCC = (PW + 1)'(DEPTH);
   localparam logic [AW-1:0] AGE_LAST = AW'(MAX_LAT - 1);

   assign pcpi_ready = a_ready;
   assign pcpi_wait  = a_wait;
   assign pcpi_wr    = a_wr;
   assign pcpi_rd    = a_rd;

   logic unused_b_wait;
   assign unused_b_wait = b_wait;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]      occ_q, occ_d;
   logic [AW-1:0]    age_q, age_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            empty, full, bypass, pop, timeout, unexp, deq, push_req, overflow, push;
   logic            mis_pop, mis_byp, mis, err_evt, mem_we;
   logic [EW-1:0]   head;
   logic [XLEN-1:0] head_rd;

   assign empty    = (occ_q == '0);
   assign full     = (occ_q == FULL_OCC);
   assign head     = mem_q[rptr_q];
   assign head_rd  = head[XLEN-1:0];
   assign bypass   = a_ready & b_ready & empty;
   assign pop      = b_ready & ~empty;
   // Head that has waited MAX_LAT edges without a DUT result is discarded on this edge.
   assign timeout  = ~empty & ~b_ready & (age_q == AGE_LAST);
   assign unexp    = b_ready & empty & ~a_ready;
   assign deq      = pop | timeout;
   assign push_req = a_ready & ~bypass;
   assign overflow = push_req & full & ~deq;
   assign push     = push_req & ~overflow;
   assign mis_pop  = pop & ({b_wr, b_rd} != head);
   assign mis_byp  = bypass & ({b_wr, b_rd} != {a_wr, a_rd});
   assign mis      = mis_pop | mis_byp;
   assign err_evt  = mis | unexp | timeout | overflow;
   assign mem_we   = push & ~clr;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      age_d  = age_q;
      err_d  = err_q;
      cnt_d  = cnt_q;
      if (clr) begin
         wptr_d = '0;
         rptr_d = '0;
         occ_d  = '0;
         age_d  = '0;
         err_d  = 1'b0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (deq)  rptr_d = rptr_q + PW'(1);
         occ_d = occ_q + (PW + 1)'(push) - (PW + 1)'(deq);
         age_d = (empty || deq) ? '0 : age_q + AW'(1);
         if (err_evt) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
         age_q  <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
         age_q  <= age_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while occupancy says they are valid.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wptr_q] <= {a_wr, a_rd};
   end

   assign err       = err_q;
   assign err_count = cnt_q;

`ifdef PCPI_LOCKSTEP_CAPTURE_EN
   logic [1:0]      code_q, code_d, cause_code;
   logic [XLEN-1:0] rda_q, rda_d, rdb_q, rdb_d, cause_a, cause_b;

   always_comb begin
      cause_code = 2'd0;
      cause_a    = '0;
      cause_b    = '0;
      if (mis) begin
         cause_code = 2'd1;
         cause_a    = bypass ? a_rd : head_rd;
         cause_b    = b_rd;
      end else if (unexp) begin
         cause_code = 2'd2;
         cause_b    = b_rd;
      end else if (timeout) begin
         cause_code = 2'd3;
         cause_a    = head_rd;
      end else if (overflow) begin
         cause_code = 2'd3;
         cause_a    = a_rd;
      end
   end

   always_comb begin
      code_d = code_q;
      rda_d  = rda_q;
      rdb_d  = rdb_q;
      if (clr) begin
         code_d = 2'd0;
         rda_d  = '0;
         rdb_d  = '0;
      end else if (err_evt && !err_q) begin
         code_d = cause_code;
         rda_d  = cause_a;
         rdb_d  = cause_b;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         code_q <= 2'd0;
         rda_q  <= '0;
         rdb_q  <= '0;
      end else begin
         code_q <= code_d;
         rda_q  <= rda_d;
         rdb_q  <= rdb_d;
      end
   end

   assign err_code = code_q;
   assign err_rd_a = rda_q;
   assign err_rd_b = rdb_q;
`else
   assign err_code = 2'd0;
   assign err_rd_a = '0;
   assign err_rd_b = '0;
`endif

endmodule

// File: tb/tb_pcpi_lockstep_cmp.sv
// Randomized self-checking bench for pcpi_lockstep_cmp against a queue-based reference model.
module tb_pcpi_lockstep_cmp;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 4;
   localparam int MAX_LAT = 64;
   localparam int CNT_W   = 16;
`ifdef PCPI_LOCKSTEP_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            a_ready = 0, a_wait = 0, a_wr = 0, b_ready = 0, b_wait = 0, b_wr = 0, clr = 0;
   logic [XLEN-1:0] a_rd = '0, b_rd = '0;
   logic            pcpi_ready, pcpi_wait, pcpi_wr, err;
   logic [XLEN-1:0] pcpi_rd, err_rd_a, err_rd_b;
   logic [CNT_W-1:0] err_count;
   logic [1:0]      err_code;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [XLEN:0]   q[$];
   int              age;
   bit              m_err;
   int              m_cnt, m_code;
   logic [XLEN-1:0] m_ra, m_rb;

   pcpi_lockstep_cmp #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .a_ready(a_ready), .a_wait(a_wait), .a_wr(a_wr), .a_rd(a_rd),
      .b_ready(b_ready), .b_wait(b_wait), .b_wr(b_wr), .b_rd(b_rd),
      .clr(clr),
      .pcpi_ready(pcpi_ready), .pcpi_wait(pcpi_wait), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
      .err(err), .err_count(err_count), .err_code(err_code),
      .err_rd_a(err_rd_a), .err_rd_b(err_rd_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      age = 0; m_err = 0; m_cnt = 0; m_code = 0; m_ra = '0; m_rb = '0;
   endtask

   // One clock edge of the checker, described as queue operations.
   task automatic model_step();
      int code;
      logic [XLEN-1:0] ra, rb;
      logic [XLEN:0] h;
      code = 0; ra = '0; rb = '0;
      if (clr) begin
         model_clear();
         return;
      end
      if (b_ready) begin
         if (q.size() == 0) begin
            if (a_ready) begin
               if ({b_wr, b_rd} != {a_wr, a_rd}) begin code = 1; ra = a_rd; rb = b_rd; end
            end else begin
               code = 2; rb = b_rd;
            end
         end else begin
            h = q.pop_front();
            age = 0;
            if ({b_wr, b_rd} != h) begin code = 1; ra = h[XLEN-1:0]; rb = b_rd; end
            if (a_ready) q.push_back({a_wr, a_rd});
         end
      end else begin
         if (q.size() > 0) begin
            if (age + 1 == MAX_LAT) begin
               h = q.pop_front();
               age = 0;
               code = 3; ra = h[XLEN-1:0];
            end else begin
               age++;
            end
         end
         if (a_ready) begin
            if (q.size() == DEPTH) begin
               if (code == 0) begin code = 3; ra = a_rd; rb = '0; end
            end else begin
               q.push_back({a_wr, a_rd});
            end
         end
      end
      if (code != 0) begin
         if (!m_err) begin m_code = code; m_ra = ra; m_rb = rb; end
         m_err = 1;
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_err"}, 64'(err), 64'(m_err));
      check_eq({tag, "_cnt"}, 64'(err_count), 64'(m_cnt));
      check_eq({tag, "_code"}, 64'(err_code), CAP ? 64'(m_code) : 64'd0);
      check_eq({tag, "_rda"}, 64'(err_rd_a), CAP ? 64'(m_ra) : 64'd0);
      check_eq({tag, "_rdb"}, 64'(err_rd_b), CAP ? 64'(m_rb) : 64'd0);
   endtask

   task automatic tick(input bit ar, input bit aw, input logic [XLEN-1:0] ard,
                       input bit br, input bit bw, input logic [XLEN-1:0] brd, input bit c);
      @(negedge clk);
      a_ready = ar; a_wr = aw; a_rd = ard;
      b_ready = br; b_wr = bw; b_rd = brd; clr = c;
      a_wait = 1'($urandom); b_wait = 1'($urandom);
      #1;
      if ($urandom_range(0, 7) == 0) begin
         check_eq("pt_ready", 64'(pcpi_ready), 64'(ar));
         check_eq("pt_wait", 64'(pcpi_wait), 64'(a_wait));
         check_eq("pt_wr", 64'(pcpi_wr), 64'(aw));
         check_eq("pt_rd", 64'(pcpi_rd), 64'(ard));
      end
      @(posedge clk);
      model_step();
      #1;
      check_state("st");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, '0, 0, 0, '0, 0);
   endtask

   initial begin
      logic [XLEN:0] hv;
      bit ar, br, aw, bw;
      logic [XLEN-1:0] ard, brd;
      int bprob;
      model_clear();

      // Reset state and pass-through during reset
      a_ready = 1; a_wr = 1; a_rd = 32'hA5A5_0001;
      #12;
      check_eq("rst_pt_rd", 64'(pcpi_rd), 64'hA5A5_0001);
      check_eq("rst_pt_ready", 64'(pcpi_ready), 64'd1);
      check_state("rst");
      @(negedge clk);
      a_ready = 0; a_wr = 0; a_rd = '0;
      resetn = 1;

      // Same-cycle match
      tick(1, 1, 32'h7, 1, 1, 32'h7, 0);
      check_eq("byp_err", 64'(err), 64'd0);
      check_eq("byp_cnt", 64'(err_count), 64'd0);

      // Skewed data mismatch
      tick(1, 0, 32'h1234_5678, 0, 0, '0, 0);
      idle(2);
      tick(0, 0, '0, 1, 0, 32'h1234_5679, 0);
      check_eq("mis_err", 64'(err), 64'd1);
      check_eq("mis_cnt", 64'(err_count), 64'd1);
      check_eq("mis_code", 64'(err_code), CAP ? 64'd1 : 64'd0);
      check_eq("mis_rda", 64'(err_rd_a), CAP ? 64'h1234_5678 : 64'd0);
      check_eq("mis_rdb", 64'(err_rd_b), CAP ? 64'h1234_5679 : 64'd0);
      tick(0, 0, '0, 0, 0, '0, 1);

      // Unexpected DUT result
      tick(0, 0, '0, 1, 1, 32'hDEAD_BEEF, 0);
      check_eq("unx_code", 64'(err_code), CAP ? 64'd2 : 64'd0);
      check_eq("unx_rdb", 64'(err_rd_b), CAP ? 64'hDEAD_BEEF : 64'd0);
      check_eq("unx_rda", 64'(err_rd_a), 64'd0);
      tick(0, 0, '0, 0, 0, '0, 1);

      // Timeout at exactly MAX_LAT
      tick(1, 0, 32'hCAFE_0001, 0, 0, '0, 0);
      idle(MAX_LAT - 1);
      check_eq("to_early", 64'(err), 64'd0);
      idle(1);
      check_eq("to_err", 64'(err), 64'd1);
      check_eq("to_code", 64'(err_code), CAP ? 64'd3 : 64'd0);
      check_eq("to_rda", 64'(err_rd_a), CAP ? 64'hCAFE_0001 : 64'd0);
      tick(0, 0, '0, 1, 0, 32'h55, 0);
      check_eq("to_empty_cnt", 64'(err_count), 64'd2);
      tick(0, 0, '0, 0, 0, '0, 1);

      // Overflow then drain
      for (int i = 1; i <= 5; i++) tick(1, 0, 32'(i), 0, 0, '0, 0);
      check_eq("ovf_cnt", 64'(err_count), 64'd1);
      check_eq("ovf_code", 64'(err_code), CAP ? 64'd3 : 64'd0);
      for (int i = 1; i <= 4; i++) tick(0, 0, '0, 1, 0, 32'(i), 0);
      check_eq("drain_cnt", 64'(err_count), 64'd1);

      // Asynchronous reset mid-burst
      tick(0, 0, '0, 0, 0, '0, 1);
      tick(0, 0, '0, 1, 0, 32'h99, 0);
      tick(1, 1, 32'h10, 0, 0, '0, 0);
      @(posedge clk);
      #3;
      resetn = 0;
      #1;
      model_clear();
      check_state("arst");
      @(negedge clk);
      resetn = 1;
      tick(0, 0, '0, 1, 0, 32'h77, 0);
      check_eq("arst_again", 64'(err), 64'd1);
      tick(1, 1, 32'h3, 0, 0, '0, 1);
      check_eq("clr_err", 64'(err), 64'd0);
      check_eq("clr_cnt", 64'(err_count), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bprob = ((i % 700) >= 600) ? 0 : (((i / 500) % 2) != 0 ? 10 : 45);
         ar  = ($urandom_range(0, 99) < 40);
         aw  = 1'($urandom);
         ard = $urandom_range(0, 15);
         br  = ($urandom_range(0, 99) < bprob);
         bw  = 1'($urandom);
         brd = $urandom_range(0, 15);
         if ($urandom_range(0, 9) != 0) begin
            if (q.size() > 0) begin
               hv = q[0];
               bw = hv[XLEN]; brd = hv[XLEN-1:0];
            end else begin
               bw = aw; brd = ard;
            end
         end
         tick(ar, aw, ard, br, bw, brd, ($urandom_range(0, 59) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
